// File: rtl/uart_tx_stage.sv
// Byte-to-serial 8N1/8N2 transmitter with a one-byte holding register so
// consecutive bytes leave the shifter back-to-back.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | line high; waits for the holding register to fill
//   ST_START | start bit (line low) for one bit period
//   ST_DATA  | eight data bits, LSB first, shifter[0] on the line
//   ST_STOP  | STOP_BITS stop periods; reloads straight into START if a
//            | byte is already waiting

module uart_tx_stage #(
   parameter int CLKS_PER_BIT = 104,
   parameter int STOP_BITS    = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_req,
   output logic       txd,
   output logic       busy,
   output logic       overrun
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

   logic [1:0]  state;
   logic [15:0] baud_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shifter;
   logic [7:0]  hold_data;
   logic        hold_full;
   logic        prev_valid;

   logic rise;
   logic bit_end;
   logic take;

   always_comb begin
      rise    = tx_valid & ~prev_valid;
      bit_end = (baud_cnt == 16'd0);
      take    = hold_full &
                ((state == ST_IDLE) |
                 ((state == ST_STOP) & bit_end & (bit_idx == STOP_LAST)));
   end

   assign busy = (state != ST_IDLE) | hold_full;

   // The shifter's take frees the holding register in the same cycle, so a
   // coincident offer is accepted rather than flagged as an overrun.
   always_ff @(posedge clock) begin
      if (!reset) begin
         prev_valid <= 1'b0;
         hold_full  <= 1'b0;
         hold_data  <= 8'h00;
         overrun    <= 1'b0;
         tx_req     <= 1'b1;
      end else begin
         prev_valid <= tx_valid;
         if (rise && (!hold_full || take)) begin
            hold_data <= tx_data;
            hold_full <= 1'b1;
            tx_req    <= 1'b0;
         end else if (take) begin
            hold_full <= 1'b0;
            tx_req    <= 1'b1;
         end
         if (rise && hold_full && !take)
            overrun <= 1'b1;
      end
   end

   // Down-counter per bit period; bit_idx counts data bits, then stop bits.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= ST_IDLE;
         baud_cnt <= 16'd0;
         bit_idx  <= 3'd0;
         shifter  <= 8'h00;
         txd      <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               txd <= 1'b1;
               if (hold_full) begin
                  shifter  <= hold_data;
                  state    <= ST_START;
                  baud_cnt <= BIT_LAST;
                  txd      <= 1'b0;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  state    <= ST_DATA;
                  bit_idx  <= 3'd0;
                  baud_cnt <= BIT_LAST;
                  txd      <= shifter[0];
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  baud_cnt <= BIT_LAST;
                  if (bit_idx == 3'd7) begin
                     state   <= ST_STOP;
                     bit_idx <= 3'd0;
                     txd     <= 1'b1;
                  end else begin
                     shifter <= {1'b0, shifter[7:1]};
                     bit_idx <= bit_idx + 3'd1;
                     txd     <= shifter[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            default: begin
               if (bit_end) begin
                  baud_cnt <= BIT_LAST;
                  if (bit_idx == STOP_LAST) begin
                     bit_idx <= 3'd0;
                     if (hold_full) begin
                        shifter <= hold_data;
                        state   <= ST_START;
                        txd     <= 1'b0;
                     end else begin
                        state   <= ST_IDLE;
                        txd     <= 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_stage.sv
// Bench for uart_tx_stage: two instances (1 and 2 stop bits) at 4 clocks/bit,
// checked every cycle against a line-level queue model plus literal checks.

module tb_uart_tx_stage;

   localparam int CPB = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;

   logic tx_req1, txd1, busy1, overrun1;
   logic tx_req2, txd2, busy2, overrun2;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   always #5 clock = ~clock;

   uart_tx_stage #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
      .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_req(tx_req1), .txd(txd1), .busy(busy1), .overrun(overrun1));

   uart_tx_stage #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
      .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_req(tx_req2), .txd(txd2), .busy(busy2), .overrun(overrun2));

   // Model: a holding slot plus a buffer of the line levels still to be sent.
   logic       lb [2][64];
   int         rd [2] = '{0, 0};
   int         ln [2] = '{0, 0};
   logic       hf [2] = '{1'b0, 1'b0};
   logic [7:0] hd [2];
   logic       ovr [2] = '{1'b0, 1'b0};
   logic       m_txd [2] = '{1'b1, 1'b1};
   logic       infr [2] = '{1'b0, 1'b0};
   logic       prevv = 1'b0;

   task automatic model_step();
      logic rise_m;
      int n;
      rise_m = tx_valid && !prevv;
      for (int k = 0; k < 2; k++) begin
         if (!reset) begin
            hf[k] = 1'b0; ovr[k] = 1'b0; rd[k] = 0; ln[k] = 0;
            m_txd[k] = 1'b1; infr[k] = 1'b0;
         end else begin
            if (rd[k] == ln[k] && hf[k]) begin
               n = 0;
               for (int c = 0; c < CPB; c++) begin lb[k][n] = 1'b0; n++; end
               for (int b = 0; b < 8; b++)
                  for (int c = 0; c < CPB; c++) begin lb[k][n] = hd[k][b]; n++; end
               for (int c = 0; c < (k + 1) * CPB; c++) begin lb[k][n] = 1'b1; n++; end
               rd[k] = 0; ln[k] = n; hf[k] = 1'b0;
            end
            if (rise_m) begin
               if (!hf[k]) begin hd[k] = tx_data; hf[k] = 1'b1; end
               else ovr[k] = 1'b1;
            end
            if (rd[k] < ln[k]) begin
               m_txd[k] = lb[k][rd[k]]; rd[k]++; infr[k] = 1'b1;
            end else begin
               m_txd[k] = 1'b1; infr[k] = 1'b0;
            end
         end
      end
      prevv = reset ? tx_valid : 1'b0;
   endtask

   initial forever begin
      @(posedge clock);
      model_step();
   end

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   initial forever begin
      @(negedge clock);
      if (chk_en) begin
         cmp("s1_txd", 64'(txd1), 64'(m_txd[0]));
         cmp("s1_tx_req", 64'(tx_req1), 64'(!hf[0]));
         cmp("s1_busy", 64'(busy1), 64'(infr[0] || hf[0]));
         cmp("s1_overrun", 64'(overrun1), 64'(ovr[0]));
         cmp("s2_txd", 64'(txd2), 64'(m_txd[1]));
         cmp("s2_tx_req", 64'(tx_req2), 64'(!hf[1]));
         cmp("s2_busy", 64'(busy2), 64'(infr[1] || hf[1]));
         cmp("s2_overrun", 64'(overrun2), 64'(ovr[1]));
      end
   end

   task automatic offer(input logic [7:0] b);
      @(posedge clock); #1;
      tx_data = b; tx_valid = 1'b1;
      @(posedge clock); #1;
      tx_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clock); #1 reset = 1'b0;
      @(posedge clock); #1 reset = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
   endtask

   task automatic wait_fall(input int k);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (((k == 0) ? txd1 : txd2) === 1'b0) begin ok = 1'b1; break; end
      end
      cmp("start_bit_seen", 64'(ok), 64'd1);
   endtask

   task automatic wait_req1();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (tx_req1 === 1'b1) begin ok = 1'b1; break; end
      end
      cmp("tx_req_return", 64'(ok), 64'd1);
   endtask

   initial begin
      logic [39:0] pat;
      int cnt;
      reset = 1'b0;
      idle(3); #1;
      reset = 1'b1;
      chk_en = 1'b1;
      idle(20);

      // 'O' on the 1-stop-bit line, waveform pinned literally
      offer(8'h4F);
      @(negedge clock);
      cmp("req_fall", 64'(tx_req1), 64'd0);
      wait_fall(0);
      cmp("req_back_at_start", 64'(tx_req1), 64'd1);
      pat = '0;
      pat[39] = txd1;
      for (int i = 1; i < 40; i++) begin
         @(negedge clock);
         pat[39 - i] = txd1;
      end
      cmp("frame_4F", 64'(pat), 64'h0F_FFF0_0F0F);
      @(negedge clock);
      cmp("busy1_end", 64'(busy1), 64'd0);
      cmp("busy2_extra_stop", 64'(busy2), 64'd1);
      idle(20);

      // "OK\n" back-to-back
      offer(8'h4F); wait_req1();
      offer(8'h4B); wait_req1();
      offer(8'h0A);
      idle(150);
      cmp("okn_no_overrun", 64'(overrun1), 64'd0);

      // third byte while holding register full
      do_reset();
      offer(8'h55);
      offer(8'hAA);
      offer(8'h33);
      idle(100);
      @(negedge clock);
      cmp("overrun_sticky", 64'(overrun1), 64'd1);

      // long level counts as one offer
      do_reset();
      @(posedge clock); #1;
      tx_data = 8'($urandom); tx_valid = 1'b1;
      idle(200); #1;
      tx_valid = 1'b0;
      idle(60);

      // reset inside data bit 3
      do_reset();
      offer(8'($urandom));
      wait_fall(0);
      idle(17); #1;
      reset = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(negedge clock);
      cmp("rst_txd", 64'(txd1), 64'd1);
      cmp("rst_tx_req", 64'(tx_req1), 64'd1);
      cmp("rst_busy", 64'(busy1), 64'd0);
      offer(8'h3C);
      idle(60);

      // 0xFF with two stop bits: 4 low + 32 data-high + 8 stop-high cycles
      offer(8'hFF);
      wait_fall(1);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (busy2 !== 1'b1) break;
         cnt++;
         @(negedge clock);
      end
      cmp("stop2_frame_len", 64'(cnt), 64'd44);
      idle(10);

      // random traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         @(posedge clock); #1;
         tx_data = 8'($urandom);
         if ($urandom_range(0, 3) == 0) tx_valid = ~tx_valid;
         reset = ($urandom_range(0, 299) != 0);
      end
      #1 reset = 1'b1; tx_valid = 1'b0;
      idle(100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
